// File: rtl/hamming_encode_stream.sv
// hamming_encode_stream: multi-lane SECDED Hamming encoder in a 2-stage valid/ready pipeline.
// Define HAMMING_ENC_ERR_INJECT_EN to add lane-0 single-bit error injection (err_inj_i / err_pos_i).
module hamming_encode_stream #(
    parameter  int DATA_WIDTH  = 32,
    parameter  int LANES       = 2,
    parameter  int CNT_WIDTH   = 16,
    // Smallest r with 2^r >= DATA_WIDTH+r+1; the nested clog2 lands on it exactly.
    localparam int P           = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH + 1) + 1),
    localparam int CODED_WIDTH = DATA_WIDTH + P,
    localparam int CODE_BITS   = P + 1
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [LANES*DATA_WIDTH-1:0]   data_in_i,
    input  logic [LANES-1:0]              lane_en_i,
    input  logic                          valid_in_i,
    output logic                          ready_out_o,
`ifdef HAMMING_ENC_ERR_INJECT_EN
    input  logic                          err_inj_i,
    input  logic [$clog2(CODED_WIDTH+1)-1:0] err_pos_i,
`endif
    output logic [LANES*CODED_WIDTH-1:0]  data_out_o,
    output logic [LANES*CODE_BITS-1:0]    parity_bits_o,
    output logic [LANES-1:0]              lane_en_o,
    output logic                          valid_out_o,
    input  logic                          ready_in_i,
    output logic [CNT_WIDTH-1:0]          beat_count_o
);

    // Returns {p[P-1:0], ext, codeword[CODED_WIDTH-1:0]} for one data word.
    function automatic logic [CODE_BITS+CODED_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] d);
        logic [CODED_WIDTH-1:0] cw;
        logic [P-1:0]           p;
        int                     di;
        cw = '0;
        p  = '0;
        di = 0;
        for (int pos = 1; pos <= CODED_WIDTH; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos-1] = d[di];
                di++;
            end
        end
        // Parity slots are still zero here, so they drop out of their own sums.
        for (int i = 0; i < P; i++) begin
            for (int pos = 1; pos <= CODED_WIDTH; pos++) begin
                if (((pos >> i) & 1) == 1) begin
                    p[i] = p[i] ^ cw[pos-1];
                end
            end
        end
        for (int i = 0; i < P; i++) begin
            cw[(1 << i) - 1] = p[i];
        end
        return {p, ^cw, cw};
    endfunction

    logic                           s1_valid_reg;
    logic [LANES*DATA_WIDTH-1:0]    s1_data_reg;
    logic [LANES-1:0]               s1_lane_en_reg;

    logic                           s2_valid_reg;
    logic [LANES*CODED_WIDTH-1:0]   s2_code_reg;
    logic [LANES*CODE_BITS-1:0]     s2_par_reg;
    logic [LANES-1:0]               s2_lane_en_reg;

    logic [CNT_WIDTH-1:0]           beat_count_reg;

    logic                           s2_adv;
    logic                           s1_adv;
    logic                           accept;
    logic                           consume;

    logic [LANES*CODED_WIDTH-1:0]   code_next;
    logic [LANES*CODE_BITS-1:0]     par_next;
    logic [CODED_WIDTH-1:0]         err_mask;

    assign s2_adv      = !s2_valid_reg || ready_in_i;
    assign s1_adv      = s1_valid_reg && s2_adv;
    assign ready_out_o = !s1_valid_reg || s2_adv;
    assign accept      = valid_in_i && ready_out_o;
    assign consume     = s2_valid_reg && ready_in_i;

`ifdef HAMMING_ENC_ERR_INJECT_EN
    localparam int POS_WIDTH = $clog2(CODED_WIDTH + 1);

    logic                 s1_err_inj_reg;
    logic [POS_WIDTH-1:0] s1_err_pos_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_err_inj_reg <= 1'b0;
            s1_err_pos_reg <= '0;
        end else if (accept) begin
            s1_err_inj_reg <= err_inj_i;
            s1_err_pos_reg <= err_pos_i;
        end
    end

    // Position 0 and positions past CODED_WIDTH match nothing, so they flip nothing.
    always_comb begin
        err_mask = '0;
        if (s1_err_inj_reg) begin
            for (int pos = 1; pos <= CODED_WIDTH; pos++) begin
                if (s1_err_pos_reg == POS_WIDTH'(pos)) begin
                    err_mask[pos-1] = 1'b1;
                end
            end
        end
    end
`else
    assign err_mask = '0;
`endif

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [CODE_BITS+CODED_WIDTH-1:0] enc;
        logic [CODED_WIDTH-1:0]           flip;

        assign enc  = encode(s1_data_reg[gi*DATA_WIDTH +: DATA_WIDTH]);
        // Only lane 0 is a target for the injected flip; parity is left untouched.
        assign flip = (gi == 0) ? err_mask : '0;

        assign code_next[gi*CODED_WIDTH +: CODED_WIDTH] =
            s1_lane_en_reg[gi] ? (enc[CODED_WIDTH-1:0] ^ flip) : '0;
        assign par_next[gi*CODE_BITS +: CODE_BITS] =
            s1_lane_en_reg[gi] ? enc[CODE_BITS+CODED_WIDTH-1 -: CODE_BITS] : '0;
    end

    // Stage 1: raw input beat.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid_reg   <= 1'b0;
            s1_data_reg    <= '0;
            s1_lane_en_reg <= '0;
        end else if (accept) begin
            s1_valid_reg   <= 1'b1;
            s1_data_reg    <= data_in_i;
            s1_lane_en_reg <= lane_en_i;
        end else if (s1_adv) begin
            s1_valid_reg   <= 1'b0;
        end
    end

    // Stage 2: encoded beat, held while downstream stalls.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s2_valid_reg   <= 1'b0;
            s2_code_reg    <= '0;
            s2_par_reg     <= '0;
            s2_lane_en_reg <= '0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_code_reg    <= code_next;
                s2_par_reg     <= par_next;
                s2_lane_en_reg <= s1_lane_en_reg;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            beat_count_reg <= '0;
        end else if (consume) begin
            beat_count_reg <= beat_count_reg + CNT_WIDTH'(1);
        end
    end

    assign valid_out_o   = s2_valid_reg;
    assign data_out_o    = s2_code_reg;
    assign parity_bits_o = s2_par_reg;
    assign lane_en_o     = s2_lane_en_reg;
    assign beat_count_o  = beat_count_reg;

endmodule

// File: tb/tb_hamming_encode_stream.sv
// Scoreboard bench for hamming_encode_stream: directed beats pushed on accept, monitor pops on output.
module tb_hamming_encode_stream;
    localparam int DW   = 32;
    localparam int LN   = 2;
    localparam int CNTW = 4;
    localparam int CW   = 38;
    localparam int CB   = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [LN*DW-1:0]     data_in;
    logic [LN-1:0]        lane_en;
    logic                 valid_in;
    logic                 ready_out;
    logic [LN*CW-1:0]     data_out;
    logic [LN*CB-1:0]     parity_bits;
    logic [LN-1:0]        lane_en_out;
    logic                 valid_out;
    logic                 ready_in;
    logic [CNTW-1:0]      beat_count;
`ifdef HAMMING_ENC_ERR_INJECT_EN
    logic                 err_inj;
    logic [5:0]           err_pos;
`endif

    hamming_encode_stream #(.DATA_WIDTH(DW), .LANES(LN), .CNT_WIDTH(CNTW)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .data_in_i     (data_in),
        .lane_en_i     (lane_en),
        .valid_in_i    (valid_in),
        .ready_out_o   (ready_out),
`ifdef HAMMING_ENC_ERR_INJECT_EN
        .err_inj_i     (err_inj),
        .err_pos_i     (err_pos),
`endif
        .data_out_o    (data_out),
        .parity_bits_o (parity_bits),
        .lane_en_o     (lane_en_out),
        .valid_out_o   (valid_out),
        .ready_in_i    (ready_in),
        .beat_count_o  (beat_count)
    );

    typedef struct packed {
        logic [LN*CW-1:0] code;
        logic [LN*CB-1:0] par;
        logic [LN-1:0]    en;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   checks  = 0;
    int   fails   = 0;
    int   accepts = 0;
    int   cyc     = 0;
    logic [CNTW-1:0] exp_cnt = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Syndrome formulation: parity word is the XOR of the positions holding a 1 data bit.
    function automatic logic [CB+CW-1:0] model(input logic [DW-1:0] d);
        logic [CW-1:0] cw;
        logic [5:0]    syn;
        int            pos;
        cw  = '0;
        syn = '0;
        pos = 0;
        for (int k = 0; k < DW; k++) begin
            pos++;
            while ((pos & (pos - 1)) == 0) pos++;
            if (d[k]) begin
                cw[pos-1] = 1'b1;
                syn = syn ^ 6'(pos);
            end
        end
        for (int i = 0; i < 6; i++) cw[(1 << i) - 1] = syn[i];
        return {syn, ^cw, cw};
    endfunction

    function automatic exp_t make_exp(input logic [LN*DW-1:0] d, input logic [LN-1:0] en);
        exp_t            e;
        logic [CB+CW-1:0] m;
        e.en = en;
        for (int l = 0; l < LN; l++) begin
            m = model(d[l*DW +: DW]);
            e.code[l*CW +: CW] = en[l] ? m[CW-1:0] : '0;
            e.par[l*CB +: CB]  = en[l] ? m[CB+CW-1:CW] : '0;
        end
        return e;
    endfunction

    // Called at a negedge; returns at a later negedge after the beat was taken.
    task automatic send(input logic [LN*DW-1:0] d, input logic [LN-1:0] en, input exp_t e);
        bit ok;
        ok = 1'b0;
        data_in  = d;
        lane_en  = en;
        valid_in = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            #1;
            if (ready_out) begin
                sb.push_back(e);
                accepts++;
                ok = 1'b1;
            end
            @(negedge clk);
        end
        valid_in = 1'b0;
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: got ready_out=0 for 100 cycles required 1");
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            #3;
            if (sb.size() == 0) done = 1'b1;
        end
        @(negedge clk);
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: got %0d beats pending required 0", sb.size());
        end
    endtask

    // Monitor: samples just after each negedge, pops and compares on every consumed beat.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (!rst_n) begin
                exp_cnt = '0;
            end else if (valid_out && ready_in) begin
                check("beat_count_track", beat_count, exp_cnt);
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_beat: got data %0h required no beat", data_out);
                end else begin
                    e = sb.pop_front();
                    check("codeword", data_out, e.code);
                    check("parity", parity_bits, e.par);
                    check("lane_en_out", lane_en_out, e.en);
                end
                $display("beat cyc=%0d lane_en=%b data=%h parity=%h", cyc, lane_en_out, data_out, parity_bits);
                pop_cyc.push_back(cyc);
                exp_cnt = exp_cnt + 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t              e;
        logic [LN*DW-1:0]  d;
        logic [LN*CW-1:0]  held;
        int                p0;

        rst_n    = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        lane_en  = '0;
        ready_in = 1'b1;
`ifdef HAMMING_ENC_ERR_INJECT_EN
        err_inj  = 1'b0;
        err_pos  = '0;
`endif
        repeat (2) @(negedge clk);
        check("rst_valid_out", valid_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_parity", parity_bits, 0);
        check("rst_lane_en_out", lane_en_out, 0);
        check("rst_beat_count", beat_count, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", ready_out, 1);

        // Data 1 in lane 0: p0=p1=1 -> codeword 0x7, parity {000011,1}.
        e.code = {38'h0, 38'h7};
        e.par  = {7'h00, 7'h07};
        e.en   = 2'b11;
        send({32'h0, 32'h1}, 2'b11, e);
        drain();
        check("count_after_first", beat_count, 1);

        // Directed table: data 2 -> 0x19/0x0B, data 3 -> 0x1E/0x0C, disabled lanes zero.
        e.code = {38'h0, 38'h7};
        e.par  = {7'h00, 7'h07};
        e.en   = 2'b01;
        send({32'h2, 32'h1}, 2'b01, e);
        e.code = {38'h1E, 38'h19};
        e.par  = {7'h0C, 7'h0B};
        e.en   = 2'b11;
        send({32'h3, 32'h2}, 2'b11, e);
        e.code = {38'h19, 38'h0};
        e.par  = {7'h0B, 7'h00};
        e.en   = 2'b10;
        send({32'h2, 32'h1}, 2'b10, e);
        drain();
        check("count_after_table", beat_count, 4);

        // 8 back-to-back beats must emerge on consecutive cycles.
        p0 = pop_cyc.size();
        for (int i = 0; i < 8; i++) begin
            d = {~(32'h1000_0000 + 32'(i)), 32'h1000_0000 + 32'(i)};
            send(d, 2'b11, make_exp(d, 2'b11));
        end
        drain();
        check("count_after_stream", beat_count, 12);
        check("stream_consecutive", pop_cyc[p0+7] - pop_cyc[p0], 7);

        // Stall: 2 accepts fill both stages, then ready_out drops and S2 holds.
        ready_in = 1'b0;
        accepts  = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    d = {32'hCAFE_0000 + 32'(i), 32'hDEAD_0000 ^ 32'(i * 7)};
                    send(d, 2'b11, make_exp(d, 2'b11));
                end
            end
            begin
                repeat (3) @(negedge clk);
                held = data_out;
                repeat (2) @(negedge clk);
                check("stall_accepts", accepts, 2);
                check("stall_ready_out", ready_out, 0);
                check("stall_valid_out", valid_out, 1);
                check("stall_hold", data_out, held);
                ready_in = 1'b1;
            end
        join
        drain();
        check("count_wrap_17", beat_count, 1);

        // Asynchronous reset with two beats in flight.
        ready_in = 1'b0;
        d = {32'h1234_5678, 32'h9ABC_DEF0};
        send(d, 2'b11, make_exp(d, 2'b11));
        send(~d, 2'b11, make_exp(~d, 2'b11));
        #3 rst_n = 1'b0;
        #1;
        check("midrst_valid_out", valid_out, 0);
        check("midrst_data_out", data_out, 0);
        check("midrst_parity", parity_bits, 0);
        check("midrst_beat_count", beat_count, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale_beat", valid_out, 0);
        end
        d = {32'hFFFF_FFFF, 32'h8000_0001};
        send(d, 2'b11, make_exp(d, 2'b11));
        send(~d, 2'b01, make_exp(~d, 2'b01));
        drain();
        check("count_after_reset", beat_count, 2);

`ifdef HAMMING_ENC_ERR_INJECT_EN
        // Flip lands on the codeword only; position 0 or beyond 38 flips nothing.
        err_inj = 1'b1;
        err_pos = 6'd5;
        e.code = {38'h0, 38'h10};
        e.par  = {7'h00, 7'h00};
        e.en   = 2'b01;
        send({32'h0, 32'h0}, 2'b01, e);
        err_pos = 6'd38;
        e.code = {38'h0, 38'h20_0000_0007};
        e.par  = {7'h00, 7'h07};
        send({32'h0, 32'h1}, 2'b01, e);
        err_pos = 6'd0;
        e.code = {38'h0, 38'h7};
        send({32'h0, 32'h1}, 2'b01, e);
        err_pos = 6'd39;
        send({32'h0, 32'h1}, 2'b01, e);
        err_inj = 1'b0;
        err_pos = 6'd5;
        send({32'h0, 32'h1}, 2'b01, e);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
